// File: rtl/sdram_phase_autotune.sv
// SDRAM clock phase calibrator: sweeps the PLL output phase over one period, scores each
// position from mem_tester counter deltas, and parks at the centre of the longest passing run.
module sdram_phase_autotune #(
  parameter int C_steps        = 32,
  parameter int C_pulse_len    = 4,
  parameter int C_settle       = 1024,
  parameter int C_dwell_passes = 2,
  parameter int C_fail_tol     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        passcount,
  input  logic [31:0]        failcount,
  output logic               phasedir,
  output logic               phasestep,
  output logic               phaseloadreg,
  output logic [7:0]         phase,
  output logic [C_steps-1:0] window,
  output logic [7:0]         best_start,
  output logic [7:0]         best_len,
  output logic               busy,
  output logic               done,
  output logic               fail
);

  localparam int         IW   = $clog2(C_steps);
  localparam logic [7:0] LAST = 8'(C_steps - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_STEP, S_SETTLE, S_SNAP, S_DWELL, S_EVAL, S_SEARCH, S_SEEK, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [7:0]  k;
  logic [7:0]  scan;
  logic [7:0]  run_len;
  logic [7:0]  run_start;
  logic [8:0]  seek_left;
  logic [31:0] p0, f0;
  logic [31:0] pass_delta, fail_delta;
  logic        pulse_last, settle_last;
  logic [IW-1:0] kidx, sidx;

  assign pass_delta  = passcount - p0;
  assign fail_delta  = failcount - f0;
  assign pulse_last  = (cnt == 32'(2 * C_pulse_len - 1));
  assign settle_last = (cnt == 32'(C_settle - 1));
  assign kidx        = k[IW-1:0];
  assign sidx        = scan[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_SETTLE;
      S_STEP:         if (pulse_last) state_nxt = S_SETTLE;
      S_SETTLE:       if (settle_last) state_nxt = S_SNAP;
      S_SNAP:         state_nxt = S_DWELL;
      S_DWELL:        if (pass_delta >= 32'(C_dwell_passes)) state_nxt = S_EVAL;
      S_EVAL:         state_nxt = (k == LAST) ? S_SEARCH : S_STEP;
      S_SEARCH:       if (scan == 8'(C_steps)) state_nxt = S_SEEK;
      S_SEEK:         if (pulse_last && seek_left == 9'd1) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    phasedir     = 1'b0;
    phaseloadreg = 1'b0;
    phasestep    = ((state == S_STEP) || (state == S_SEEK)) && (cnt < 32'(C_pulse_len));
    busy         = (state != S_IDLE) && (state != S_DONE);
    done         = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      k          <= '0;
      scan       <= '0;
      run_len    <= '0;
      run_start  <= '0;
      seek_left  <= '0;
      p0         <= '0;
      f0         <= '0;
      phase      <= '0;
      window     <= '0;
      best_start <= '0;
      best_len   <= '0;
      fail       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            window     <= '0;
            best_start <= '0;
            best_len   <= '0;
            fail       <= 1'b0;
            k          <= '0;
            cnt        <= '0;
          end
        end
        S_STEP, S_SEEK: begin
          cnt <= pulse_last ? '0 : cnt + 32'd1;
          // phase advances together with the falling edge of phasestep
          if (cnt == 32'(C_pulse_len - 1))
            phase <= (phase == LAST) ? '0 : phase + 8'd1;
          if (state == S_SEEK && pulse_last)
            seek_left <= seek_left - 9'd1;
        end
        S_SETTLE: cnt <= settle_last ? '0 : cnt + 32'd1;
        S_SNAP: begin
          p0 <= passcount;
          f0 <= failcount;
        end
        S_EVAL: begin
          window[kidx] <= (fail_delta <= 32'(C_fail_tol));
          if (k != LAST) k <= k + 8'd1;
          cnt       <= '0;
          scan      <= '0;
          run_len   <= '0;
          run_start <= '0;
        end
        S_SEARCH: begin
          if (scan < 8'(C_steps)) begin
            if (window[sidx]) begin
              if (run_len + 8'd1 > best_len) begin
                best_len   <= run_len + 8'd1;
                best_start <= (run_len == 8'd0) ? scan : run_start;
              end
              if (run_len == 8'd0) run_start <= scan;
              run_len <= run_len + 8'd1;
            end else begin
              run_len <= '0;
            end
            scan <= scan + 8'd1;
          end else begin
            // one step back to the sweep origin, then best_start + best_len/2 further
            seek_left <= (best_len == 8'd0) ? 9'd1
                       : 9'd1 + {1'b0, best_start} + {2'b00, best_len[7:1]};
            fail      <= (best_len == 8'd0);
            cnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_phase_autotune.sv
// Directed bench for sdram_phase_autotune with a mock mem_tester whose pass window is
// indexed by the tracked PLL position; counters advance every 100 cycles.
module tb_sdram_phase_autotune;

  localparam int NSTEPS = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       passcount, failcount;
  logic              phasedir, phasestep, phaseloadreg;
  logic [7:0]        phase;
  logic [NSTEPS-1:0] window;
  logic [7:0]        best_start, best_len;
  logic              busy, done, fail;

  int total = 0;
  int bad = 0;

  logic [7:0]  mask = 8'h00;
  logic        mock_run = 1'b0;
  logic [31:0] pc_off = 32'd0;
  logic [31:0] pc_ticks = 32'd0;
  logic [31:0] fc_ticks = 32'd0;
  int          tick = 0;
  logic [2:0]  pll_pos = 3'd0;
  int          pulses = 0;
  logic [37:0] outs;

  sdram_phase_autotune #(
    .C_steps(NSTEPS), .C_pulse_len(4), .C_settle(16), .C_dwell_passes(2), .C_fail_tol(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .passcount(passcount), .failcount(failcount),
    .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg), .phase(phase),
    .window(window), .best_start(best_start), .best_len(best_len),
    .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  assign passcount = pc_off + pc_ticks;
  assign failcount = fc_ticks;
  assign outs = {phasedir, phasestep, phaseloadreg, phase, window, best_start, best_len,
                 busy, done, fail};

  always @(negedge clk) begin
    if (mock_run) begin
      tick = tick + 1;
      if (tick >= 100) begin
        tick = 0;
        pc_ticks = pc_ticks + 32'd1;
        if (!mask[pll_pos]) fc_ticks = fc_ticks + 32'd1;
      end
    end
  end

  always @(negedge phasestep or negedge rst_n) begin
    if (!rst_n) pll_pos = 3'd0;
    else        pll_pos = pll_pos + 3'd1;
  end

  always @(posedge phasestep or negedge rst_n) begin
    if (!rst_n) pulses = 0;
    else        pulses = pulses + 1;
  end

  task automatic do_reset();
    mock_run = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit quiet;
    #1;
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", outs);
    end
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (outs !== '0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL idle_quiet got=nonzero output exp=all zero");
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL idle_pulses got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_sweep(input string nm, input logic [7:0] m, input logic [7:0] ew,
                            input logic [7:0] es, input logic [7:0] el, input logic [7:0] ep,
                            input logic ef, input int epul);
    bit ok;
    do_reset();
    mask = m;
    mock_run = 1'b1;
    pulse_start();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy got=%b exp=1", nm, busy);
    end
    wait_done(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s done_timeout got=0 exp=1", nm);
    end
    total++;
    if (window !== ew) begin
      bad++;
      $display("FAIL %s window got=%h exp=%h", nm, window, ew);
    end
    total++;
    if (best_start !== es || best_len !== el) begin
      bad++;
      $display("FAIL %s best got=%0d/%0d exp=%0d/%0d", nm, best_start, best_len, es, el);
    end
    total++;
    if (phase !== ep || {3'b000, phase[4:0]} !== {5'd0, pll_pos}) begin
      bad++;
      $display("FAIL %s phase got=%0d pll=%0d exp=%0d", nm, phase, pll_pos, ep);
    end
    total++;
    if (fail !== ef || busy !== 1'b0 || phasedir !== 1'b0 || phaseloadreg !== 1'b0) begin
      bad++;
      $display("FAIL %s flags got=fail%b busy%b dir%b load%b exp=fail%b busy0 dir0 load0",
               nm, fail, busy, phasedir, phaseloadreg, ef);
    end
    total++;
    if (pulses !== epul) begin
      bad++;
      $display("FAIL %s pulses got=%0d exp=%0d", nm, pulses, epul);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    mask = 8'hFF;
    pc_off = 32'hFFFF_FFFE - pc_ticks;
    pulse_start();
    repeat (40) @(negedge clk);
    pc_off = pc_off + 32'd1;
    repeat (30) @(negedge clk);
    total++;
    if (pulses !== 0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wrap_one_pass got=pulses%0d busy%b exp=pulses0 busy1", pulses, busy);
    end
    pc_off = pc_off + 32'd1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pulses == 1) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wrap_two_pass got=pulses%0d exp=pulses1", pulses);
    end
    mock_run = 1'b1;
    wait_done(ok);
    total++;
    if (!ok || window !== 8'hFF || best_start !== 8'd0 || best_len !== 8'd8 || phase !== 8'd4) begin
      bad++;
      $display("FAIL wrap_result got=ok%b w%h s%0d l%0d p%0d exp=ok1 wff s0 l8 p4",
               ok, window, best_start, best_len, phase);
    end
  endtask

  task automatic test_busy_start_and_reset();
    bit ok;
    do_reset();
    mask = 8'b0111_1100;
    mock_run = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (pulses >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (50) @(negedge clk);
    total++;
    if (!ok || busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_mid_sweep got=ok%b busy%b exp=ok1 busy1", ok, busy);
    end
    pulse_start();
    wait_done(ok);
    total++;
    if (!ok || pulses !== 12 || phase !== 8'd4 || window !== 8'h7C || best_len !== 8'd5) begin
      bad++;
      $display("FAIL start_ignored got=ok%b pulses%0d p%0d w%h l%0d exp=ok1 pulses12 p4 w7c l5",
               ok, pulses, phase, window, best_len);
    end
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (phasestep === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (!ok || phasestep !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_step got=ok%b phasestep%b exp=ok1 phasestep0", ok, phasestep);
    end
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h exp=0", outs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sweep("window_2_6", 8'b0111_1100, 8'b0111_1100, 8'd2, 8'd5, 8'd4, 1'b0, 12);
    test_sweep("tie",        8'b0110_0110, 8'b0110_0110, 8'd1, 8'd2, 8'd2, 1'b0, 10);
    test_sweep("none",       8'b0000_0000, 8'b0000_0000, 8'd0, 8'd0, 8'd0, 1'b1, 8);
    test_wrap();
    test_busy_start_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
